// File: rtl/audio_i2s_tx_pkg.sv
// audio_tx_pkg: shared FSM state type, frame constant and sample scaler for audio_i2s_tx.
// AUDIO_TX_SAT_EN selects saturation instead of wrap-around in scale_sample.
package audio_tx_pkg;
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} tx_state_t;
    localparam int DEF_SAMPLE_BITS = 16;
    localparam int DEF_CLK_DIV = 4;
    localparam int FRAME_CLKS = 2 * DEF_SAMPLE_BITS * 2 * DEF_CLK_DIV;
    function automatic logic [63:0] scale_sample(input logic signed [63:0] d, input int shift, input int bits);
        logic signed [63:0] w;
        logic signed [63:0] hi;
        w = d >>> shift;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
`ifdef AUDIO_TX_SAT_EN
        w = (w > hi) ? hi : (w < -hi - 64'sd1) ? -hi - 64'sd1 : w;
`else
        w = w;
`endif
        return w & ((hi <<< 1) | 64'sd1);
    endfunction
endpackage

// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: FIFO-side read port and serial DAC outputs of the I2S transmitter.
interface audio_i2s_tx_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] left_dout;
    logic [DATA_WIDTH-1:0] right_dout;
    logic left_empty;
    logic right_empty;
    logic left_rd_en;
    logic right_rd_en;
    logic bclk;
    logic lrclk;
    logic sdata;
    logic underrun;
    logic running;
    modport master (
        output left_dout, right_dout, left_empty, right_empty,
        input left_rd_en, right_rd_en, bclk, lrclk, sdata, underrun, running
    );
    modport slave (
        input left_dout, right_dout, left_empty, right_empty,
        output left_rd_en, right_rd_en, bclk, lrclk, sdata, underrun, running
    );
endinterface

// File: rtl/audio_i2s_tx_bclk.sv
// audio_bclk_gen: bit clock divider with bit-start (bclk fall) and bit-last strobes, idle at zero when disabled.
module audio_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    output logic bclk_o,
    output logic bit_start_o,
    output logic bit_last_o
);
    localparam int CW = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic bclk_q;
    assign cnt_d = (!en_i || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    assign bclk_o = bclk_q;
    assign bit_start_o = en_i && cnt_q == '0;
    assign bit_last_o = en_i && cnt_q == LAST;
    // bclk is registered from the next count so it tracks cnt_q without decode glitches
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bclk_q <= en_i && cnt_d >= HALF;
        end
    end
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: pops L/R FIFO pairs, scales them and shifts out a gapless left-justified I2S stream.
// Build with AUDIO_TX_SAT_EN to saturate instead of truncate the scaled samples.
module audio_i2s_tx
    import audio_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SAMPLE_BITS = 16,
    parameter int SHIFT = 10,
    parameter int CLK_DIV = 4
) (
    input logic clock,
    input logic reset,
    audio_i2s_tx_if.slave bus
);
    localparam int CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_BITS);
    if (SAMPLE_BITS < 2 || SAMPLE_BITS > DATA_WIDTH || CLK_DIV < 1) begin : g_bad_cfg
        $error("audio_i2s_tx: illegal SAMPLE_BITS/CLK_DIV");
    end
    tx_state_t state_q;
    logic [SAMPLE_BITS-1:0] shift_q;
    logic [SAMPLE_BITS-1:0] right_q;
    logic [CW-1:0] bit_cnt_q;
    logic lrclk_q;
    logic sdata_q;
    logic running_q;
    logic bit_start;
    logic bit_last;
    logic chan_end;
    logic fetch;
    logic pop;
    logic [SAMPLE_BITS-1:0] l_w;
    logic [SAMPLE_BITS-1:0] r_w;
    audio_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .clock(clock),
        .reset(reset),
        .en_i(state_q != IDLE),
        .bclk_o(bus.bclk),
        .bit_start_o(bit_start),
        .bit_last_o(bit_last)
    );
    // bit_cnt_q counts started bits, so it reaches SAMPLE_BITS inside the final bit of a channel
    assign chan_end = bit_last && bit_cnt_q == LAST_BIT;
    assign fetch = state_q == RIGHT && chan_end;
    assign pop = !reset && !bus.left_empty && !bus.right_empty && (state_q == IDLE || fetch);
    assign bus.left_rd_en = pop;
    assign bus.right_rd_en = pop;
    assign bus.underrun = !reset && fetch && !pop;
    assign bus.lrclk = lrclk_q;
    assign bus.sdata = sdata_q;
    assign bus.running = running_q;
    // a missed pop yields zero words, which is the silent frame
    assign l_w = pop ? SAMPLE_BITS'(scale_sample(64'($signed(bus.left_dout)), SHIFT, SAMPLE_BITS)) : '0;
    assign r_w = pop ? SAMPLE_BITS'(scale_sample(64'($signed(bus.right_dout)), SHIFT, SAMPLE_BITS)) : '0;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            right_q <= '0;
            bit_cnt_q <= '0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            running_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (pop) begin
                state_q <= LEFT;
                shift_q <= l_w;
                right_q <= r_w;
                sdata_q <= l_w[SAMPLE_BITS-1];
                bit_cnt_q <= '0;
                running_q <= 1'b1;
            end
        end else if (bit_start) begin
            shift_q <= shift_q << 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end else if (chan_end) begin
            bit_cnt_q <= '0;
            lrclk_q <= state_q == LEFT;
            state_q <= (state_q == LEFT) ? RIGHT : LEFT;
            shift_q <= (state_q == LEFT) ? right_q : l_w;
            sdata_q <= (state_q == LEFT) ? right_q[SAMPLE_BITS-1] : l_w[SAMPLE_BITS-1];
            if (state_q == RIGHT) right_q <= r_w;
        end else if (bit_last) begin
            sdata_q <= shift_q[SAMPLE_BITS-1];
        end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: scoreboard bench driving two transmitters (SHIFT 0 and 10) from one shared FIFO model.
module tb_audio_i2s_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    audio_i2s_tx_if #(.DATA_WIDTH(32)) ia ();
    audio_i2s_tx_if #(.DATA_WIDTH(32)) ib ();
    audio_i2s_tx #(.DATA_WIDTH(32), .SAMPLE_BITS(16), .SHIFT(0), .CLK_DIV(2)) dut_a (
        .clock(clk), .reset(rst), .bus(ia)
    );
    audio_i2s_tx #(.DATA_WIDTH(32), .SAMPLE_BITS(16), .SHIFT(10), .CLK_DIV(2)) dut_b (
        .clock(clk), .reset(rst), .bus(ib)
    );
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pops = 0;
    int unders = 0;
    int last_fetch = -1;
    int start = -1;
    int words_a = 0;
    int words_b = 0;
    logic [31:0] lq[$];
    logic [31:0] rq[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic pb_a = 1'b0, pb_b = 1'b0;
    logic [31:0] acc_a = '0, acc_b = '0;
    int nb_a = 0, nb_b = 0, lr_a = -1, lr_b = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // independent reference: sign-extend, arithmetic shift, then clamp or wrap to 16 bits
    function automatic logic [15:0] model(input logic [31:0] d, input int sh);
        logic signed [63:0] w;
        w = {{32{d[31]}}, d};
        w = w >>> sh;
`ifdef AUDIO_TX_SAT_EN
        if (w > 64'sd32767) w = 64'sd32767;
        else if (w < -64'sd32768) w = -64'sd32768;
`endif
        return w[15:0];
    endfunction

    task automatic refresh();
        ia.left_dout = lq.size() != 0 ? lq[0] : '0;
        ia.right_dout = rq.size() != 0 ? rq[0] : '0;
        ia.left_empty = lq.size() == 0;
        ia.right_empty = rq.size() == 0;
        ib.left_dout = ia.left_dout;
        ib.right_dout = ia.right_dout;
        ib.left_empty = ia.left_empty;
        ib.right_empty = ia.right_empty;
    endtask

    task automatic dec(input string tag, input logic bc, input logic sd, input logic lr, inout logic pb,
                       inout logic [31:0] acc, inout int nb, inout int lrise, output logic done);
        done = 1'b0;
        if (rst) begin
            nb = 0;
            lrise = -1;
        end else if (bc && !pb) begin
            if (lrise >= 0) chk({tag, "_bclk_period"}, 64'(cyc - lrise), 64'd4);
            lrise = cyc;
            chk({tag, "_lrclk"}, 64'(lr), 64'(nb >= 16));
            acc = {acc[30:0], sd};
            nb++;
            if (nb == 32) begin
                nb = 0;
                done = 1'b1;
            end
        end
        pb = bc;
    endtask

    task automatic step();
        logic p, da, db;
        @(negedge clk);
        cyc++;
        p = ia.left_rd_en | ia.right_rd_en | ib.left_rd_en | ib.right_rd_en;
        if (rst) begin
            exp_a.delete();
            exp_b.delete();
            last_fetch = -1;
            start = -1;
        end
        if (p) begin
            chk("pop_pair", {ia.left_rd_en, ia.right_rd_en, ib.left_rd_en, ib.right_rd_en,
                             lq.size() != 0, rq.size() != 0}, 64'h3F);
            if (lq.size() != 0 && rq.size() != 0) begin
                exp_a.push_back({model(lq[0], 0), model(rq[0], 0)});
                exp_b.push_back({model(lq[0], 10), model(rq[0], 10)});
            end
            if (!ia.running) start = cyc;
            pops++;
        end
        if (ia.underrun | ib.underrun) begin
            chk("underrun", {ia.underrun, ib.underrun, p}, 64'b110);
            exp_a.push_back('0);
            exp_b.push_back('0);
            unders++;
        end
        if (p | ia.underrun) begin
            if (last_fetch >= 0) chk("frame_len", 64'(cyc - last_fetch), 64'd128);
            last_fetch = cyc;
        end
        if (start >= 0 && cyc == start + 1 && exp_a.size() != 0)
            chk("frame_start", {ia.running, ib.running, ia.bclk, ia.lrclk, ia.sdata},
                {2'b11, 2'b00, exp_a[0][31]});
        dec("a", ia.bclk, ia.sdata, ia.lrclk, pb_a, acc_a, nb_a, lr_a, da);
        dec("b", ib.bclk, ib.sdata, ib.lrclk, pb_b, acc_b, nb_b, lr_b, db);
        if (da) begin
            words_a++;
            chk("word_a_queued", 64'(exp_a.size() != 0), 64'd1);
            if (exp_a.size() != 0) chk("word_a", 64'(acc_a), 64'(exp_a.pop_front()));
        end
        if (db) begin
            words_b++;
            chk("word_b_queued", 64'(exp_b.size() != 0), 64'd1);
            if (exp_b.size() != 0) chk("word_b", 64'(acc_b), 64'(exp_b.pop_front()));
        end
        @(posedge clk);
        #1;
        if (p && lq.size() != 0 && rq.size() != 0) begin
            void'(lq.pop_front());
            void'(rq.pop_front());
        end
        refresh();
    endtask

    initial begin
        refresh();
        repeat (3) step();
        chk("reset_a", {ia.bclk, ia.lrclk, ia.sdata, ia.left_rd_en, ia.right_rd_en, ia.underrun, ia.running}, 64'd0);
        chk("reset_b", {ib.bclk, ib.lrclk, ib.sdata, ib.left_rd_en, ib.right_rd_en, ib.underrun, ib.running}, 64'd0);
        lq.push_back(32'h0000A5A5); rq.push_back(32'h00003C3C);
        lq.push_back(32'h00012345); rq.push_back(32'hFFF00000);
        lq.push_back(32'h00040000); rq.push_back(32'hFFFFFC00);
        refresh();
        rst = 1'b0;
        for (int i = 0; i < 10 && pops == 0; i++) step();
        chk("first_pop", 64'(pops), 64'd1);
        repeat (532) step();
        chk("three_pops", 64'(pops), 64'd3);
        chk("two_silent", 64'(unders), 64'd2);
        lq.push_back(32'h00007FFF);
        refresh();
        repeat (128) step();
        chk("half_empty_pops", 64'(pops), 64'd3);
        chk("half_empty_underrun", 64'(unders), 64'd3);
        chk("left_kept", 64'(lq.size()), 64'd1);
        rq.push_back(32'hFFFF8000);
        refresh();
        repeat (128) step();
        chk("refill_pop", 64'(pops), 64'd4);
        chk("refill_no_underrun", 64'(unders), 64'd3);
        lq.push_back(32'h80000000); rq.push_back(32'h7FFFFFFF);
        refresh();
        repeat (30) step();
        rst = 1'b1;
        step();
        chk("midreset_a", {ia.bclk, ia.lrclk, ia.sdata, ia.left_rd_en, ia.right_rd_en, ia.underrun, ia.running}, 64'd0);
        chk("midreset_b", {ib.bclk, ib.lrclk, ib.sdata, ib.left_rd_en, ib.right_rd_en, ib.underrun, ib.running}, 64'd0);
        step();
        chk("reset_no_pop", 64'(pops), 64'd4);
        rst = 1'b0;
        for (int i = 0; i < 5 && pops == 4; i++) step();
        chk("restart_pop", 64'(pops), 64'd5);
        repeat (140) step();
        chk("fifo_drained", 64'(lq.size() + rq.size()), 64'd0);
        chk("frames_a", 64'(words_a), 64'd7);
        chk("frames_b", 64'(words_b), 64'd7);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Reader at the far end of the left and right output FIFOs of the FM stereo receiver chain.
- Pops one left/right sample pair per audio frame and scales each 32-bit fixed-point sample to a SAMPLE_BITS-wide signed word.
- Serializes the pair MSB-first as a left-justified I2S-style stream (bclk, lrclk, sdata) for an external DAC.
- Runs gapless once started; if the FIFOs run dry it inserts silent frames and flags an underrun.

Parameters:
- DATA_WIDTH, 32: width of FIFO data words.
- SAMPLE_BITS, 16: bits transmitted per channel; legal range 2..DATA_WIDTH.
- SHIFT, 10: arithmetic right shift applied to each sample (removes the quantization scale).
- CLK_DIV, 4: system clocks per bclk half-period; must be >= 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- left_dout  in  DATA_WIDTH  left FIFO head word (show-ahead: valid while left_empty=0).
- left_empty  in  1  left FIFO empty.
- left_rd_en  out  1  pop left FIFO.
- right_dout  in  DATA_WIDTH  right FIFO head word (show-ahead).
- right_empty  in  1  right FIFO empty.
- right_rd_en  out  1  pop right FIFO.
- bclk  out  1  serial bit clock.
- lrclk  out  1  0 = left channel, 1 = right channel.
- sdata  out  1  serial data, MSB first.
- underrun  out  1  one-cycle pulse when a silent frame is substituted.
- running  out  1  high once the first frame has started.

Behaviour:
- Reset: state IDLE. bclk=0, lrclk=0, sdata=0, left_rd_en=0, right_rd_en=0, underrun=0, running=0. Divider and bit counters are cleared. Reset mid-frame abandons the frame immediately; no pop is in flight.
- FSM states:
  - IDLE: waits for left_empty=0 and right_empty=0. In that cycle both rd_en go high for exactly one cycle, both heads are latched, and the state moves to LEFT.
  - LEFT: transmits SAMPLE_BITS bits of the left word with lrclk=0, then moves to RIGHT.
  - RIGHT: transmits SAMPLE_BITS bits of the right word with lrclk=1, then moves to LEFT, never back to IDLE.
- Bit timing: each bit lasts 2*CLK_DIV clocks. bclk is low for the first CLK_DIV clocks of the bit and high for the next CLK_DIV. sdata and lrclk change only in the cycle bclk falls (bit start).
- Frame length: 2*SAMPLE_BITS*2*CLK_DIV clocks. The first frame starts the cycle after the IDLE pop, with sdata = left MSB; running rises that same cycle.
- Next-frame fetch: happens in the last clock of the final RIGHT bit.
  - Both FIFOs non-empty: one-cycle pop of both and latch of both heads. The next frame follows with no gap.
  - Either FIFO empty: no pop on either FIFO, both latched words forced to 0, underrun pulses that cycle. The pair is always popped together, so L/R alignment is never broken.
- Scaling: w = signed(dout) >>> SHIFT (sign-extending), then reduced to SAMPLE_BITS (see optional feature).
- rd_en is never asserted while the corresponding empty=1 and is never held for more than one cycle per frame.

Optional Feature:
- Macro: AUDIO_TX_SAT_EN.
- Defined: w is saturated to the signed SAMPLE_BITS range [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1].
- Undefined: w is truncated to its low SAMPLE_BITS bits (wrap-around).

Decomposition:
- Package audio_tx_pkg holds:
  - typedef enum {IDLE, LEFT, RIGHT} tx_state_t;
  - function scale_sample (shift plus saturate/truncate, selected by the macro);
  - localparam FRAME_CLKS.
- Sub-module audio_bclk_gen, parameter CLK_DIV:
  - generates bclk, plus strobes bit_start (bclk falling) and bit_last (final clock of the bit);
  - held at zero while disabled.

Test Plan (CLK_DIV=2, SAMPLE_BITS=16, SHIFT=0 unless noted):
- Single pair L=0x0000A5A5, R=0x00003C3C loaded after reset → one pop cycle, then sdata = 1010010110100101 with lrclk=0, then 0011110000111100 with lrclk=1; each bit 4 clocks; frame = 128 clocks.
- SHIFT=10, L=0x00040000 → transmitted word 0x0100.
- L=0x00012345:
  - with AUDIO_TX_SAT_EN → 0x7FFF;
  - without → 0x2345;
  - L=0xFFF00000 with the macro → 0x8000.
- Three pairs preloaded, continuous run → exactly 3 pops spaced 128 clocks apart, no bclk gap, then a zero frame with underrun pulsing once per silent frame.
- Left non-empty, right empty at a frame boundary → no pop on either FIFO, zero frame, underrun=1; once right is filled, the next boundary pops both.
- Reset asserted 50 clocks into a frame → next cycle all outputs are 0, state IDLE, no rd_en; restart pops the next queued pair.
